// File: rtl/vector_mem_sequencer_if.sv
// Bundle between decoder/data-memory side and the vector memory sequencer.
// master = decoder and memory environment, slave = sequencer.
interface vector_mem_sequencer_if #(
  parameter int LANES  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                    start;
  logic                    is_store;
  logic [ADDR_W-1:0]       base_addr;
  logic [7:0]              stride;
  logic [LANES*DATA_W-1:0] store_vec;
  logic                    stall;
  logic                    busy;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_we;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;
  logic [LANES*DATA_W-1:0] load_vec;
  logic                    vreg_we;
  logic                    done;

  modport master (
    output start, is_store, base_addr, stride, store_vec, mem_rdata,
    input  stall, busy, mem_addr, mem_we, mem_wdata, load_vec, vreg_we, done
  );

  modport slave (
    input  start, is_store, base_addr, stride, store_vec, mem_rdata,
    output stall, busy, mem_addr, mem_we, mem_wdata, load_vec, vreg_we, done
  );
endinterface

// File: rtl/vector_mem_sequencer.sv
// Runs vector load/store as one memory access per lane; store LANES+1, load LANES+2 cycles.
// No backpressure: stall freezes fetch while busy, start outside IDLE is dropped.
module vector_mem_sequencer #(
  parameter int LANES  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input logic                  clk,
  input logic                  rst,
  vector_mem_sequencer_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [1:0]        state;
  logic [IW-1:0]     lane;
  logic              st_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] stride_q;
  logic [DATA_W-1:0] st_lane [LANES];
  logic [DATA_W-1:0] ld_lane [LANES];
  logic              issuing;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      lane     <= '0;
      st_q     <= 1'b0;
      addr_q   <= '0;
      stride_q <= '0;
      for (int l = 0; l < LANES; l++) begin
        st_lane[l] <= '0;
        ld_lane[l] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state    <= S_ISSUE;
            lane     <= '0;
            st_q     <= bus.is_store;
            addr_q   <= bus.base_addr;
            stride_q <= ADDR_W'(bus.stride);
            for (int l = 0; l < LANES; l++)
              st_lane[l] <= bus.store_vec[l*DATA_W +: DATA_W];
          end
        end
        S_ISSUE: begin
          // Read data lags its address by one cycle, so this cycle's rdata belongs to lane-1.
          if (!st_q && lane != '0)
            ld_lane[lane - IW'(1)] <= bus.mem_rdata;
          addr_q <= addr_q + stride_q;
          if (lane == IW'(LANES-1)) begin
            lane  <= '0;
            state <= st_q ? S_DONE : S_DRAIN;
          end else begin
            lane <= lane + IW'(1);
          end
        end
        S_DRAIN: begin
          ld_lane[LANES-1] <= bus.mem_rdata;
          state            <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign issuing = (state == S_ISSUE);

  always_comb begin
    bus.stall     = rst && ((state == S_IDLE && bus.start) || state == S_ISSUE || state == S_DRAIN);
    bus.busy      = (state != S_IDLE);
    bus.mem_addr  = issuing ? addr_q : '0;
    bus.mem_we    = issuing && st_q;
    bus.mem_wdata = (issuing && st_q) ? st_lane[lane] : '0;
    bus.done      = (state == S_DONE);
    bus.vreg_we   = (state == S_DONE) && !st_q;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_pack
    assign bus.load_vec[g*DATA_W +: DATA_W] = ld_lane[g];
  end
endmodule

// File: doc/vector_mem_sequencer.md
# vector_mem_sequencer

Multi-cycle sequencer that runs vector load/store instructions of the vector ASIP against the single-ported, word-wide data memory. It sits between the decoder and the data-memory port of `processor`. On a vector memory instruction it stalls fetch/PC, issues one scalar memory access per vector lane, and collects loaded words into a lane vector for register write-back. Scalar memory traffic uses the memory port only while the sequencer is idle.

## Interface
Parameters:
- `LANES`, 4: vector lanes; legal range ≥1.
- `DATA_W`, 32: lane and memory word width.
- `ADDR_W`, 32: byte address width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `start`  in  1  a vector memory instruction is in decode; sampled only in IDLE.
- `is_store`  in  1  1 = vector store, 0 = vector load; sampled with `start`.
- `base_addr`  in  ADDR_W  byte address of lane 0; sampled with `start`.
- `stride`  in  8  unsigned byte stride between lanes, zero-extended; sampled with `start`.
- `store_vec`  in  LANES*DATA_W  store data; lane i is bits [i*DATA_W +: DATA_W]; sampled with `start`.
- `stall`  out  1  holds PC and fetch.
- `busy`  out  1  state ≠ IDLE.
- `mem_addr`  out  ADDR_W  data-memory address.
- `mem_we`  out  1  data-memory write enable.
- `mem_wdata`  out  DATA_W  data-memory write data.
- `mem_rdata`  in  DATA_W  data-memory read data, valid 1 cycle after the address is presented.
- `load_vec`  out  LANES*DATA_W  gathered load data, lane-packed like `store_vec`.
- `vreg_we`  out  1  vector register write strobe, loads only.
- `done`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - `start`=1 latches `is_store`, `base_addr`, `stride` and `store_vec`, clears lane counter `i` to 0, and goes to ISSUE.
  - `start`=0 stays in IDLE.
- ISSUE: each cycle drives `mem_addr` = base + i*stride, computed mod 2^ADDR_W (address wrap is silent).
  - Store: `mem_we`=1, `mem_wdata` = latched lane i.
  - Load: `mem_we`=0. `mem_rdata` is captured into `load_vec` lane i-1 when i>0.
  - `i` increments each cycle. After lane LANES-1 is issued, a store goes to DONE and a load goes to DRAIN.
- DRAIN (load only): captures `mem_rdata` into lane LANES-1, then goes to DONE. Memory outputs are idle.
- DONE: `done`=1. For a load, `vreg_we`=1 and `load_vec` holds all lanes. Then goes to IDLE.
- `start` in any state other than IDLE is ignored and not queued.
- Idle memory outputs (IDLE, DRAIN, DONE): `mem_addr`=0, `mem_we`=0, `mem_wdata`=0.
- `load_vec` holds its value until the next load overwrites it; stores never modify it.
- `stall` = (IDLE & `start`) | ISSUE | DRAIN. This is the only combinational input-to-output path. `stall` is low in DONE, so the PC advances in the same cycle as `done`.
- LANES=1:
  - Store: IDLE→ISSUE→DONE.
  - Load: IDLE→ISSUE→DRAIN→DONE.

## Timing
- Reset (`rst`=0, asynchronous, from any state, including mid-sequence):
  - State IDLE, `i`=0, `load_vec`=0, all latched operands 0.
  - `stall`, `busy`, `mem_we`, `vreg_we`, `done` = 0; `mem_addr` = 0; `mem_wdata` = 0.
  - An aborted sequence performs no further memory writes.
  - Release is synchronous to the next `clk` edge.
- Cycle numbering: `start` accepted in cycle 0.
  - Lane i is issued in cycle 1+i.
  - Store: `done` in cycle LANES+1. Total stall = LANES+1 cycles (cycles 0..LANES).
  - Load: lane i data is captured at the end of cycle 2+i, DRAIN is cycle LANES+1, `done`/`vreg_we` in cycle LANES+2. Total stall = LANES+2 cycles.
- A new `start` can be accepted the cycle after DONE, giving back-to-back operations with one bubble (the DONE cycle).
- `busy` is high from cycle 1 through the DONE cycle inclusive.
- Outputs other than `stall` are registered or decoded from registered state only.

## Test plan
- Reset values: hold `rst`=0 with random inputs → every output is 0. Release `rst` with `start`=0 → state remains IDLE and all outputs stay 0.
- Store, LANES=4: base=0x100, stride=4, store_vec lanes = {0xA0,0xA1,0xA2,0xA3} → cycles 1–4 show `mem_we`=1, addr 0x100/0x104/0x108/0x10C with matching data. `done`=1 in cycle 5. `stall` is high in cycles 0–4 and low in cycle 5.
- Load, LANES=4: base=0x40, stride=8, memory model returns addr^0xFFFF → `load_vec` lanes = {0xFFBF,0xFFB7,0xFFAF,0xFFA7}. `vreg_we`=`done`=1 in cycle 6. `mem_we` stays 0 throughout.
- Address wrap: base=0xFFFFFFF8, stride=4, store → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Mid-op reset: assert `rst`=0 in cycle 2 of a store → from that point no further `mem_we`, no `done`, and all outputs are 0. A new `start` after release executes normally.
- Ignored start / back-to-back: pulse `start` in cycle 3 of a load → no effect on the operation in flight. A second `start` in the cycle after DONE → accepted, and the second operation completes with the correct data.
